// File: rtl/gf163_pkg.sv
// Shared constants and types for the GF(2^163) digit-serial operand feeder.
package gf163_pkg;

  localparam int M    = 163;
  localparam int D    = 32;
  localparam int NDIG = 6;
  localparam int PADW = NDIG * D;
  localparam int IDXW = 3;

  typedef logic [IDXW-1:0] idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feed_state_e;

  localparam idx_t IDX_HI = idx_t'(NDIG - 1);

endpackage

// File: rtl/gf163_digit_cnt.sv
// Digit index counter: load on accept, step on each non-last transfer.
// Count direction follows GF163_FEED_LSB_FIRST_EN (defined: up 0..5, else down 5..0).
module gf163_digit_cnt
  import gf163_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic step,
  output idx_t idx,
  output logic first,
  output logic last
);

`ifdef GF163_FEED_LSB_FIRST_EN
  localparam idx_t IDX_START = '0;
  localparam idx_t IDX_END   = IDX_HI;
`else
  localparam idx_t IDX_START = IDX_HI;
  localparam idx_t IDX_END   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      idx <= '0;
    end else if (load) begin
      idx <= IDX_START;
    end else if (step) begin
`ifdef GF163_FEED_LSB_FIRST_EN
      idx <= idx + idx_t'(1);
`else
      idx <= idx - idx_t'(1);
`endif
    end
  end

  assign first = (idx == IDX_START);
  assign last  = (idx == IDX_END);

endmodule

// File: rtl/gf163_digit_feeder.sv
// Operand feeder: holds A and streams B as six 32-bit digits with first/last/index sideband.
// Build option GF163_FEED_LSB_FIRST_EN selects LSB-first digit order (default MSB-first).
module gf163_digit_feeder
  import gf163_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  a_in,
  input  logic [M-1:0]  b_in,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [D-1:0]  b_digit,
  output idx_t          dig_idx,
  output logic          dig_first,
  output logic          dig_last,
  output logic [M-1:0]  a_out,
  output feed_state_e   fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // dig_valid never depends on dig_ready; in_ready may rise in the last-digit cycle
  // when that digit is being consumed, so the next pair loads without a bubble.

  feed_state_e      state;
  feed_state_e      state_nxt;
  logic [PADW-1:0]  sh;
  logic [M-1:0]     a_q;
  logic             accept;
  logic             xfer;
  logic             cnt_first;
  logic             cnt_last;
  logic             shift;

  assign dig_valid = (state == STREAM);
  assign xfer      = dig_valid & dig_ready;
  assign in_ready  = (state == IDLE) | (xfer & cnt_last);
  assign accept    = in_valid & in_ready;
  assign shift     = xfer & ~cnt_last & ~accept;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = STREAM;
    end else if (xfer && cnt_last) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      sh  <= '0;
      a_q <= '0;
    end else if (accept) begin
      sh  <= PADW'(b_in);
      a_q <= a_in;
    end else if (shift) begin
`ifdef GF163_FEED_LSB_FIRST_EN
      sh <= sh >> D;
`else
      sh <= sh << D;
`endif
    end
  end

  gf163_digit_cnt u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .load  (accept),
    .step  (shift),
    .idx   (dig_idx),
    .first (cnt_first),
    .last  (cnt_last)
  );

  // Sideband flags are masked in IDLE so reset leaves them all low.
  assign dig_first = dig_valid & cnt_first;
  assign dig_last  = dig_valid & cnt_last;

`ifdef GF163_FEED_LSB_FIRST_EN
  assign b_digit = sh[D-1:0];
`else
  assign b_digit = sh[PADW-1 -: D];
`endif

  assign a_out     = a_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Directed bench for gf163_digit_feeder: reset, digit order, stall, back-to-back, mid-stream reset.
module tb_gf163_digit_feeder;
  import gf163_pkg::*;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  a_in;
  logic [M-1:0]  b_in;
  logic          dig_valid;
  logic          dig_ready;
  logic [D-1:0]  b_digit;
  idx_t          dig_idx;
  logic          dig_first;
  logic          dig_last;
  logic [M-1:0]  a_out;
  feed_state_e   fsm_state;

  int total;
  int bad;
  logic [D-1:0] exp_q[$];

  gf163_digit_feeder dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .b_digit   (b_digit),
    .dig_idx   (dig_idx),
    .dig_first (dig_first),
    .dig_last  (dig_last),
    .a_out     (a_out),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected digits are listed most-significant first; LSB-first builds emit them reversed.
  task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5);
    exp_q.delete();
`ifdef GF163_FEED_LSB_FIRST_EN
    exp_q.push_back(d5); exp_q.push_back(d4); exp_q.push_back(d3);
    exp_q.push_back(d2); exp_q.push_back(d1); exp_q.push_back(d0);
`else
    exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
    exp_q.push_back(d3); exp_q.push_back(d4); exp_q.push_back(d5);
`endif
  endtask

  function automatic int exp_idx(input int k);
`ifdef GF163_FEED_LSB_FIRST_EN
    return k;
`else
    return 5 - k;
`endif
  endfunction

  task automatic check_digit(input string tag, input int k, input logic [M-1:0] a, input logic [31:0] d);
    chk({tag, ".valid"}, 192'(dig_valid), 192'(1'b1));
    chk({tag, ".digit"}, 192'(b_digit), 192'(d));
    chk({tag, ".idx"},   192'(dig_idx), 192'(exp_idx(k)));
    chk({tag, ".first"}, 192'(dig_first), 192'(k == 0));
    chk({tag, ".last"},  192'(dig_last), 192'(k == 5));
    chk({tag, ".a_out"}, 192'(a_out), 192'(a));
  endtask

  // driver: streams the six queued digits with dig_ready high, optionally stalling at position stall_k
  task automatic stream(input string tag, input logic [M-1:0] a, input int stall_k, input bit next_loaded);
    logic [31:0] d;
    for (int k = 0; k < 6; k++) begin
      d = exp_q.pop_front();
      check_digit($sformatf("%s.d%0d", tag, k), k, a, d);
      chk($sformatf("%s.in_ready%0d", tag, k), 192'(in_ready), 192'(k == 5));
      if (k == stall_k) begin
        dig_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_digit($sformatf("%s.stall%0d", tag, s), k, a, d);
          chk($sformatf("%s.stall_ready%0d", tag, s), 192'(in_ready), 192'(1'b0));
        end
        dig_ready = 1'b1;
      end
      tick();
    end
    if (!next_loaded) begin
      chk({tag, ".end_valid"}, 192'(dig_valid), 192'(1'b0));
      chk({tag, ".end_ready"}, 192'(in_ready), 192'(1'b1));
      chk({tag, ".end_state"}, 192'(fsm_state), 192'(IDLE));
    end
  endtask

  task automatic offer(input logic [M-1:0] a, input logic [M-1:0] b);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".in_ready"}, 192'(in_ready), 192'(1'b1));
    chk({tag, ".valid"},    192'(dig_valid), 192'(1'b0));
    chk({tag, ".digit"},    192'(b_digit), 192'(0));
    chk({tag, ".idx"},      192'(dig_idx), 192'(0));
    chk({tag, ".first"},    192'(dig_first), 192'(1'b0));
    chk({tag, ".last"},     192'(dig_last), 192'(1'b0));
    chk({tag, ".a_out"},    192'(a_out), 192'(0));
  endtask

  logic [167:0] a_pat;
  logic [M-1:0] a1, a2, ax, ay;
  logic [M-1:0] bx, by;

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b1;
    in_valid  = 1'b0;
    dig_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    a_pat     = {21{8'h5A}};
    a1        = a_pat[M-1:0];
    a2        = ~a1;
    ax        = {3'h1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    ay        = {3'h6, 32'hDEADBEEF, 32'h01020304, 32'hA5A5A5A5, 32'h0BADF00D, 32'h76543210};
    bx        = {3'h2, 32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};
    by        = {3'h3, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0, 32'hCAFEBABE};

    // reset then idle
    tick();
    tick();
    check_reset_state("rst");
    rstn = 1'b0;
    tick();
    check_reset_state("idle");
    dig_ready = 1'b1;

    // single top bit
    offer(a1, {1'b1, 162'b0});
    push_exp(32'h00000004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    stream("topbit", a1, -1, 1'b0);

    // all-ones B
    offer(a2, {M{1'b1}});
    push_exp(32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    stream("ones", a2, -1, 1'b0);

    // stall three cycles on the digit with index 3
    offer(ax, {3'h5, 32'h01234567, 32'h89ABCDEF, 32'h11223344, 32'h55667788, 32'h99AABBCC});
    push_exp(32'h00000005, 32'h01234567, 32'h89ABCDEF, 32'h11223344, 32'h55667788, 32'h99AABBCC);
`ifdef GF163_FEED_LSB_FIRST_EN
    stream("stall", ax, 3, 1'b0);
`else
    stream("stall", ax, 2, 1'b0);
`endif

    // back-to-back: second pair held valid through the first operation
    offer(ax, bx);
    a_in     = ay;
    b_in     = by;
    in_valid = 1'b1;
    push_exp(32'h00000002, 32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005);
    stream("b2b_x", ax, -1, 1'b1);
    in_valid = 1'b0;
    chk("b2b.state", 192'(fsm_state), 192'(STREAM));
    push_exp(32'h00000003, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0, 32'hCAFEBABE);
    stream("b2b_y", ay, -1, 1'b0);

    // mid-stream reset at the digit with index 2
    offer(ay, bx);
    push_exp(32'h00000002, 32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005);
    for (int k = 0; k < 3; k++) begin
      check_digit($sformatf("pre_rst.d%0d", k), k, ay, exp_q.pop_front());
      tick();
    end
    chk("pre_rst.idx2", 192'(dig_idx), 192'(exp_idx(3)));
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    check_reset_state("mid_rst");
    chk("mid_rst.state", 192'(fsm_state), 192'(IDLE));

    // a fresh pair streams from the start
    offer(a1, by);
    push_exp(32'h00000003, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0, 32'hCAFEBABE);
    stream("post_rst", a1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf163_digit_feeder.md
# gf163_digit_feeder

Upstream operand feeder for the digit-serial GF(2^163) systolic multiplier with digit size 32. It accepts a 163-bit operand pair (A, B) with a valid/ready handshake. It holds A stable for the whole operation and streams B to the multiplier array one 32-bit digit per cycle, six digits per operation, MSB digit first. It also emits first/last/index sideband so the downstream accumulate/reduce registers know where each operation starts and ends.

## Interface
- M, 163, field degree (operand width)
- D, 32, digit width
- NDIG, 6, digits per operand, ceil(M/D); B is zero-extended to NDIG*D = 192 bits
- clk  input  1  clock; all logic on rising edge
- rstn  input  1  reset, synchronous and active-high (asserted = 1, sampled on clk)
- in_valid  input  1  operand pair presented
- in_ready  output  1  feeder can accept a pair this cycle
- a_in  input  163  operand A
- b_in  input  163  operand B
- dig_valid  output  1  b_digit/a_out/sideband valid
- dig_ready  input  1  multiplier consumes the digit this cycle
- b_digit  output  32  current digit of B
- dig_idx  output  3  index of current digit (5..0 by default)
- dig_first  output  1  current digit is the first of the operation
- dig_last  output  1  current digit is the last of the operation
- a_out  output  163  registered A, constant over all digits of one operation

## Operation
- FSM has two states: IDLE and STREAM.
- in_ready = (state==IDLE) | (dig_valid & dig_ready & dig_last). Back-to-back operations have no bubble.
- Accept (in_valid & in_ready):
  - capture a_out <= a_in
  - capture shift register sh <= {29'b0, b_in}
  - set idx <= NDIG-1
  - state <= STREAM
- Digit transfer: dig_valid & dig_ready.
  - Without a transfer, b_digit, dig_idx, a_out and the flags hold. Stall is unbounded.
  - On a non-last transfer: sh <= sh << 32, idx <= idx-1.
  - On a last transfer with no simultaneous accept: state <= IDLE, and dig_valid drops next cycle.
  - On a last transfer with a simultaneous accept: the new pair is loaded and STREAM continues.
- Outputs:
  - b_digit = sh[191:160]
  - dig_first = (idx==NDIG-1)
  - dig_last = (idx==0)
  - dig_valid = (state==STREAM)
- The top digit carries B[162:160] in bits 2:0; bits 31:3 are 0.
- in_valid without in_ready is ignored. The upstream holds its data; the feeder does not latch it.
- Reset in any state, including mid-stream:
  - next state IDLE, in_ready=1
  - dig_valid=0, b_digit=0, dig_idx=0, dig_first=0, dig_last=0, a_out=0
  - the partial operation is discarded with no residual digit
- GF(2) arithmetic is not performed here. This block is pure buffering and sequencing.

## Timing
- Accept at edge t: first digit valid after t, so latency is 1 cycle.
- With dig_ready held high: digits at t+1..t+6, dig_last at t+6. A new pair accepted at t+6 gives its first digit at t+7.
- Throughput: one operation per NDIG cycles, sustained.
- All outputs are registered or decoded from registers only. No combinational path from dig_ready/in_valid to any output except in_ready, which depends on dig_ready.

## Configuration
- Macro: GF163_FEED_LSB_FIRST_EN.
- Undefined (default): MSB-first order.
  - idx counts 5→0
  - shift left, b_digit = sh[191:160]
- Defined: LSB-first order.
  - idx counts 0→5
  - dig_first = (idx==0), dig_last = (idx==NDIG-1)
  - shift right, b_digit = sh[31:0]
  - the top digit (zero-padded) is emitted last
- Handshake, latency and reset behaviour are identical in both builds.

## Structure
- Shared package gf163_pkg holds:
  - constants M, D, NDIG, PADW (=NDIG*D)
  - the digit index width
  - the feeder state enum {IDLE, STREAM}
- One sub-module, gf163_digit_cnt: the idx down/up counter with load, decrement-on-transfer and first/last decode. The direction is selected by the macro.

## Test plan
- Reset then idle: hold rstn=1 for 2 cycles, then release. Required: in_ready=1, dig_valid=0, a_out=0, b_digit=0.
- B = 1<<162, A = 0x5A…, dig_ready=1:
  - digits 0x00000004, then five 0x00000000
  - dig_idx 5,4,3,2,1,0
  - dig_first only on the first digit, dig_last only on the sixth
  - a_out constant = A
- B = all-ones (163 bits): digits 0x00000007, then 0xFFFFFFFF ×5. With LSB_FIRST_EN: 0xFFFFFFFF ×5, then 0x00000007.
- Stall: drop dig_ready for 3 cycles on digit idx 3. Required: b_digit, dig_idx and a_out hold during the stall; the sequence resumes unchanged; in_ready stays 0 throughout.
- Back-to-back: present a second pair with in_valid held during the first op. Required:
  - accepted in the dig_last cycle
  - its first digit appears on the very next cycle
  - 12 digits occupy 12 consecutive cycles
- Mid-stream reset: assert rstn at digit idx 2. Required:
  - next cycle dig_valid=0, all outputs zero, in_ready=1
  - a new pair streams correctly from idx 5
